// File: rtl/spi_frame_controller_if.sv
// Request/response and SPI pin bundle between a frame requester, the controller and the peripheral.
// master = controller side, slave = requester plus peripheral side.
interface spi_frame_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       cipo;

  modport master (
    input  req_valid, req_rw, req_addr, req_data, cipo,
    output req_ready, busy, done, rx_data, sclk, copi, ncs
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_data, cipo,
    input  req_ready, busy, done, rx_data, sclk, copi, ncs
  );
endinterface

// File: rtl/spi_frame_controller.sv
// SPI mode-0 initiator: one 16-bit frame per accepted request, 1 + 35*CLK_DIV cycles per frame.
// Accepts only in IDLE (req_ready); requests held while busy stay pending until the next IDLE.
module spi_frame_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  spi_frame_controller_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  half_cnt;
  logic [4:0]  bit_cnt;
  logic [14:0] shift_reg;
  logic [7:0]  cap_reg;
  logic        half_end;

  assign half_end = (half_cnt == HALF_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      half_cnt      <= 8'd0;
      bit_cnt       <= 5'd0;
      shift_reg     <= 15'd0;
      cap_reg       <= 8'd0;
      bus.ncs       <= 1'b1;
      bus.sclk      <= 1'b0;
      bus.copi      <= 1'b0;
      bus.done      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rx_data   <= 8'd0;
    end else begin
      bus.done <= 1'b0;
      if (state != IDLE) begin
        half_cnt <= half_end ? 8'd0 : half_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            // Bit 15 goes straight to copi; the register keeps bits 14:0.
            shift_reg     <= {bus.req_addr, bus.req_data};
            bus.copi      <= bus.req_rw;
            bus.ncs       <= 1'b0;
            bus.busy      <= 1'b1;
            bus.req_ready <= 1'b0;
            half_cnt      <= 8'd0;
            bit_cnt       <= 5'd0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (half_end) begin
            bus.sclk <= 1'b1;
            cap_reg  <= {cap_reg[6:0], bus.cipo};
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_end) begin
            if (bus.sclk) begin
              bus.sclk <= 1'b0;
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt != 5'd15) begin
                bus.copi  <= shift_reg[14];
                shift_reg <= {shift_reg[13:0], 1'b0};
              end
            end else if (bit_cnt == 5'd16) begin
              state <= HOLD;
            end else begin
              bus.sclk <= 1'b1;
              cap_reg  <= {cap_reg[6:0], bus.cipo};
            end
          end
        end
        HOLD: begin
          if (half_end) begin
            bus.ncs     <= 1'b1;
            bus.done    <= 1'b1;
            bus.copi    <= 1'b0;
            bus.rx_data <= cap_reg;
            state       <= GAP;
          end
        end
        GAP: begin
          if (half_end) begin
            bus.busy      <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
